// File: rtl/rsa_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rsa_modexp_ctrl
// Brief    : RSA decryption sequencer. Fetches R mod M / R^2 mod M from the
//            constant unit, then runs left-to-right square-and-multiply on a
//            shared Montgomery multiplier. Optional modulus constant cache is
//            enabled by defining RSA_CONST_CACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_modexp_ctrl #(
   parameter int W = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] M,
   input  logic [W-1:0] C,
   input  logic [W-1:0] D,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] P,
   output logic         crt_start,
   output logic [W:0]   crt_M,
   input  logic [W:0]   crt_R_r,
   input  logic [W-1:0] crt_R_t,
   input  logic         crt_done,
   output logic         mm_start,
   output logic [W-1:0] mm_A,
   output logic [W-1:0] mm_B,
   output logic [W-1:0] mm_M,
   input  logic [W-1:0] mm_Z,
   input  logic         mm_done
);

   localparam int IW = $clog2(W);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CONST    = 3'd1,
      S_TOMONT   = 3'd2,
      S_SCAN     = 3'd3,
      S_SQR      = 3'd4,
      S_MUL      = 3'd5,
      S_FROMMONT = 3'd6,
      S_FIN      = 3'd7
   } state_t;

   state_t        r_state;
   logic [W-1:0]  r_m;
   logic [W-1:0]  r_c;
   logic [W-1:0]  r_d;
   logic [W-1:0]  r_rt;
   logic [W-1:0]  r_x;
   logic [W-1:0]  r_cm;
   logic [IW-1:0] r_i;
   logic          r_issued;

`ifdef RSA_CONST_CACHE_EN
   logic [W-1:0]  r_cache_m;
   logic [W-1:0]  r_cache_rr;
   logic          r_cache_vld;
`endif

   logic          w_mm_state;
   logic          w_mm_ack;
   logic [W-1:0]  w_opa;
   logic [W-1:0]  w_opb;
   logic          w_unused_rr_msb;

   // R mod M is always below M, so the extra constant-unit bit carries nothing.
   assign w_unused_rr_msb = crt_R_r[W];

   assign crt_M = {1'b0, r_m};
   assign mm_M  = r_m;

   assign w_mm_state = (r_state == S_TOMONT) || (r_state == S_SQR) ||
                       (r_state == S_MUL)    || (r_state == S_FROMMONT);

   // A done seen while our own start pulse is still out belongs to nothing we issued.
   assign w_mm_ack = r_issued && !mm_start && mm_done;

   always_comb begin
      w_opa = r_x;
      w_opb = r_x;
      case (r_state)
         S_TOMONT: begin
            w_opa = r_c;
            w_opb = r_rt;
         end
         S_MUL:      w_opb = r_cm;
         S_FROMMONT: w_opb = {{(W-1){1'b0}}, 1'b1};
         default:    ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         P         <= '0;
         crt_start <= 1'b0;
         mm_start  <= 1'b0;
         mm_A      <= '0;
         mm_B      <= '0;
         r_m       <= '0;
         r_c       <= '0;
         r_d       <= '0;
         r_rt      <= '0;
         r_x       <= '0;
         r_cm      <= '0;
         r_i       <= '0;
         r_issued  <= 1'b0;
`ifdef RSA_CONST_CACHE_EN
         r_cache_m   <= '0;
         r_cache_rr  <= '0;
         r_cache_vld <= 1'b0;
`endif
      end else begin
         crt_start <= 1'b0;
         mm_start  <= 1'b0;
         done      <= 1'b0;

         // Every multiplier state launches its call on its first cycle.
         if (w_mm_state && !r_issued) begin
            mm_A     <= w_opa;
            mm_B     <= w_opb;
            mm_start <= 1'b1;
            r_issued <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_m      <= M;
                  r_c      <= C;
                  r_d      <= D;
                  busy     <= 1'b1;
                  r_i      <= IW'(W - 1);
                  r_issued <= 1'b0;
`ifdef RSA_CONST_CACHE_EN
                  if (r_cache_vld && (M == r_cache_m)) begin
                     r_x     <= r_cache_rr;
                     r_state <= S_TOMONT;
                  end else
`endif
                  begin
                     crt_start <= 1'b1;
                     r_state   <= S_CONST;
                  end
               end
            end

            S_CONST: begin
               if (crt_done && !crt_start) begin
                  r_rt    <= crt_R_t;
                  r_x     <= crt_R_r[W-1:0];
                  r_state <= S_TOMONT;
`ifdef RSA_CONST_CACHE_EN
                  r_cache_m   <= r_m;
                  r_cache_rr  <= crt_R_r[W-1:0];
                  r_cache_vld <= 1'b1;
`endif
               end
            end

            S_TOMONT: begin
               if (w_mm_ack) begin
                  r_cm     <= mm_Z;
                  r_issued <= 1'b0;
                  r_state  <= S_SCAN;
               end
            end

            S_SCAN: begin
               if (r_d[r_i]) begin
                  r_state <= S_SQR;
               end else if (r_i != '0) begin
                  r_i <= r_i - IW'(1);
               end else begin
                  r_state <= S_FROMMONT;
               end
            end

            S_SQR: begin
               if (w_mm_ack) begin
                  r_x      <= mm_Z;
                  r_issued <= 1'b0;
                  if (r_d[r_i]) begin
                     r_state <= S_MUL;
                  end else if (r_i == '0) begin
                     r_state <= S_FROMMONT;
                  end else begin
                     r_i <= r_i - IW'(1);
                  end
               end
            end

            S_MUL: begin
               if (w_mm_ack) begin
                  r_x      <= mm_Z;
                  r_issued <= 1'b0;
                  if (r_i == '0) begin
                     r_state <= S_FROMMONT;
                  end else begin
                     r_i     <= r_i - IW'(1);
                     r_state <= S_SQR;
                  end
               end
            end

            S_FROMMONT: begin
               if (w_mm_ack) begin
                  P        <= mm_Z;
                  done     <= 1'b1;
                  r_issued <= 1'b0;
                  r_state  <= S_FIN;
               end
            end

            S_FIN: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
